// File: rtl/frame_aligner_pkg.sv
`default_nettype none
// ============================================================================
// Module  : frame_aligner_pkg
// Brief   : Shared constants and state encoding for the frame aligner.
// Revision: 1.0 - initial release
// ============================================================================
package frame_aligner_pkg;

    localparam logic [7:0] HEAD1_LSB = 8'hAA;
    localparam logic [7:0] HEAD1_MSB = 8'hAF;
    localparam logic [7:0] HEAD2_LSB = 8'h55;
    localparam logic [7:0] HEAD2_MSB = 8'hBA;

    localparam int FRAME_LEN         = 12;
    localparam int DEF_PAYLOAD_LEN   = FRAME_LEN - 2;
    localparam int DEF_LOCK_FRAMES   = 3;
    localparam int DEF_UNLOCK_FRAMES = 4;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/frame_aligner_header_check.sv
`default_nettype none
// ============================================================================
// Module  : frame_aligner_header_check
// Brief   : Flags whether the last two received bytes form a legal header.
// Revision: 1.0 - initial release
// ============================================================================
module frame_aligner_header_check
    import frame_aligner_pkg::*;
(
    input  logic [7:0] i_prev_byte,
    input  logic [7:0] i_cur_byte,
    output logic       o_valid
);

    assign o_valid = ((i_prev_byte == HEAD1_LSB) && (i_cur_byte == HEAD1_MSB)) ||
                     ((i_prev_byte == HEAD2_LSB) && (i_cur_byte == HEAD2_MSB));

endmodule
`default_nettype wire

// File: rtl/frame_aligner.sv
`default_nettype none
// ============================================================================
// Module  : frame_aligner
// Brief   : Byte-stream frame synchronizer with lock/unlock hysteresis.
// Revision: 1.0 - initial release
// ============================================================================
module frame_aligner
    import frame_aligner_pkg::*;
#(
    parameter int PAYLOAD_LEN   = DEF_PAYLOAD_LEN,
    parameter int LOCK_FRAMES   = DEF_LOCK_FRAMES,
    parameter int UNLOCK_FRAMES = DEF_UNLOCK_FRAMES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    output logic [3:0] fr_byte_position,
    output logic       frame_detect
);

    localparam int GW = $clog2(LOCK_FRAMES + 1);
    localparam int BW = $clog2(UNLOCK_FRAMES + 1);

    localparam logic [3:0]    c_last_pos = 4'(PAYLOAD_LEN + 1);
    localparam logic [GW-1:0] c_lock     = GW'(LOCK_FRAMES);
    localparam logic [BW-1:0] c_unlock   = BW'(UNLOCK_FRAMES);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [7:0]    r_prev_byte;
    logic [3:0]    r_pos;
    logic [3:0]    w_pos_nxt;
    logic [3:0]    w_pos_inc;
    logic [GW-1:0] r_good_cnt;
    logic [GW-1:0] w_good_nxt;
    logic [BW-1:0] r_bad_cnt;
    logic [BW-1:0] w_bad_nxt;
    logic          r_frame_detect;
    logic          w_detect_nxt;
    logic          w_hdr_valid;

    frame_aligner_header_check u_header_check (
        .i_prev_byte (r_prev_byte),
        .i_cur_byte  (rx_data),
        .o_valid     (w_hdr_valid)
    );

    always_comb begin
        w_pos_inc    = (r_pos == c_last_pos) ? 4'd0 : r_pos + 4'd1;
        w_state_nxt  = r_state;
        w_pos_nxt    = r_pos;
        w_good_nxt   = r_good_cnt;
        w_bad_nxt    = r_bad_cnt;
        w_detect_nxt = r_frame_detect;

        case (r_state)
            HUNT: begin
                w_pos_nxt = 4'd0;
                if (w_hdr_valid) begin
                    w_pos_nxt  = 4'd1;
                    w_good_nxt = GW'(1);
                    if (c_lock <= GW'(1)) begin
                        w_state_nxt  = LOCKED;
                        w_detect_nxt = 1'b1;
                    end else begin
                        w_state_nxt = SYNC;
                    end
                end
            end
            SYNC: begin
                w_pos_nxt = w_pos_inc;
                // Header is judged on the edge that lands on its MSB byte
                if (w_pos_inc == 4'd1) begin
                    if (w_hdr_valid) begin
                        if (r_good_cnt + GW'(1) >= c_lock) begin
                            w_good_nxt   = c_lock;
                            w_state_nxt  = LOCKED;
                            w_detect_nxt = 1'b1;
                        end else begin
                            w_good_nxt = r_good_cnt + GW'(1);
                        end
                    end else begin
                        w_state_nxt = HUNT;
                        w_pos_nxt   = 4'd0;
                        w_good_nxt  = '0;
                        w_bad_nxt   = '0;
                    end
                end
            end
            LOCKED: begin
                w_pos_nxt = w_pos_inc;
                if (w_pos_inc == 4'd1) begin
                    if (w_hdr_valid) begin
                        w_bad_nxt = '0;
                    end else if (r_bad_cnt + BW'(1) >= c_unlock) begin
                        w_state_nxt  = HUNT;
                        w_pos_nxt    = 4'd0;
                        w_good_nxt   = '0;
                        w_bad_nxt    = '0;
                        w_detect_nxt = 1'b0;
                    end else begin
                        w_bad_nxt = r_bad_cnt + BW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt  = HUNT;
                w_pos_nxt    = 4'd0;
                w_good_nxt   = '0;
                w_bad_nxt    = '0;
                w_detect_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= HUNT;
            r_prev_byte    <= 8'd0;
            r_pos          <= 4'd0;
            r_good_cnt     <= '0;
            r_bad_cnt      <= '0;
            r_frame_detect <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_prev_byte    <= rx_data;
            r_pos          <= w_pos_nxt;
            r_good_cnt     <= w_good_nxt;
            r_bad_cnt      <= w_bad_nxt;
            r_frame_detect <= w_detect_nxt;
        end
    end

    // Position register is forced to zero outside alignment, so it drives the port directly
    assign fr_byte_position = r_pos;
    assign frame_detect     = r_frame_detect;

endmodule
`default_nettype wire

// File: tb/tb_frame_aligner.sv
`default_nettype none
// ============================================================================
// Module  : tb_frame_aligner
// Brief   : Self-checking bench for frame_aligner (scoreboard + directed checks).
// Revision: 1.0 - initial release
// ============================================================================
module tb_frame_aligner;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic [3:0] fr_byte_position;
    logic       frame_detect;

    int n_cmp = 0;
    int n_err = 0;

    logic [4:0] sb[$];

    // Reference model: 0 = hunting, 1 = aligned, 2 = locked
    int         m_st;
    int         m_pos;
    int         m_good;
    int         m_bad;
    logic [7:0] m_prev;

    always #5 clk = ~clk;

    frame_aligner #(
        .PAYLOAD_LEN   (10),
        .LOCK_FRAMES   (3),
        .UNLOCK_FRAMES (4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .rx_data          (rx_data),
        .fr_byte_position (fr_byte_position),
        .frame_detect     (frame_detect)
    );

    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed det/pos=0x%0h expected det/pos=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_dir(input string tag, input logic exp_det, input logic [3:0] exp_pos);
        check(tag, {frame_detect, fr_byte_position}, {exp_det, exp_pos});
    endtask

    function automatic logic [7:0] rnd_byte();
        logic [7:0] v;
        do v = 8'($urandom_range(0, 255)); while (v == 8'hAA || v == 8'h55);
        return v;
    endfunction

    task automatic model_update(input logic r, input logic [7:0] b);
        logic hdr;
        if (r) begin
            m_st = 0; m_pos = 0; m_good = 0; m_bad = 0; m_prev = 8'h00;
        end else begin
            hdr = (m_prev == 8'hAA && b == 8'hAF) || (m_prev == 8'h55 && b == 8'hBA);
            if (m_st == 0) begin
                if (hdr) begin
                    m_st = 1; m_pos = 1; m_good = 1;
                end
            end else begin
                m_pos = (m_pos + 1) % 12;
                if (m_pos == 1) begin
                    if (m_st == 1) begin
                        if (hdr) begin
                            m_good++;
                            if (m_good == 3) m_st = 2;
                        end else begin
                            m_st = 0; m_pos = 0; m_good = 0; m_bad = 0;
                        end
                    end else begin
                        if (hdr) begin
                            m_bad = 0;
                        end else begin
                            m_bad++;
                            if (m_bad == 4) begin
                                m_st = 0; m_pos = 0; m_good = 0; m_bad = 0;
                            end
                        end
                    end
                end
            end
            m_prev = b;
        end
    endtask

    task automatic step(input logic r, input logic [7:0] b);
        logic [4:0] e;
        @(negedge clk);
        reset   = r;
        rx_data = b;
        model_update(r, b);
        sb.push_back({(m_st == 2), 4'(m_pos)});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("sb", {frame_detect, fr_byte_position}, e);
    endtask

    task automatic send_hdr(input logic [7:0] lsb, input logic [7:0] msb);
        step(1'b0, lsb);
        step(1'b0, msb);
    endtask

    task automatic send_payload(input int n);
        for (int i = 0; i < n; i++) step(1'b0, rnd_byte());
    endtask

    initial begin
        #100_000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        rx_data = 8'h00;

        // Reset with random data, then idle
        step(1'b1, rnd_byte());
        step(1'b1, rnd_byte());
        check_dir("reset", 1'b0, 4'd0);
        repeat (5) step(1'b0, rnd_byte());
        check_dir("idle", 1'b0, 4'd0);

        // Three valid headers -> lock
        send_hdr(8'hAA, 8'hAF);
        check_dir("hdr1", 1'b0, 4'd1);
        send_payload(10);
        check_dir("end_frame1", 1'b0, 4'd11);
        send_hdr(8'h55, 8'hBA);
        check_dir("hdr2", 1'b0, 4'd1);
        send_payload(10);
        send_hdr(8'hAA, 8'hAF);
        check_dir("lock", 1'b1, 4'd1);
        send_payload(10);

        // Four bad headers -> unlock
        send_hdr(8'h55, 8'hBA);
        send_payload(10);
        for (int i = 0; i < 4; i++) begin
            send_hdr(8'h12, 8'h34);
            if (i < 3) check_dir("bad_hold", 1'b1, 4'd1);
            else       check_dir("unlock", 1'b0, 4'd0);
            send_payload(10);
        end
        check_dir("after_unlock", 1'b0, 4'd0);

        // Relock, three bad then one good keeps lock
        for (int i = 0; i < 3; i++) begin
            send_hdr(8'hAA, 8'hAF);
            send_payload(10);
        end
        check_dir("relock", 1'b1, 4'd11);
        for (int i = 0; i < 3; i++) begin
            send_hdr(8'h12, 8'h34);
            check_dir("bad3_hold", 1'b1, 4'd1);
            send_payload(10);
        end
        send_hdr(8'h55, 8'hBA);
        check_dir("recover", 1'b1, 4'd1);
        send_payload(10);
        send_hdr(8'h12, 8'h34);
        check_dir("single_bad", 1'b1, 4'd1);
        send_payload(10);
        send_hdr(8'hAA, 8'hAF);
        send_payload(10);

        // Two good, one bad -> hunt; overlapping header search
        step(1'b1, rnd_byte());
        check_dir("reset2", 1'b0, 4'd0);
        for (int i = 0; i < 2; i++) begin
            send_hdr(8'hAA, 8'hAF);
            send_payload(10);
        end
        send_hdr(8'h12, 8'h34);
        check_dir("sync_bad", 1'b0, 4'd0);
        send_payload(15);
        check_dir("no_lock", 1'b0, 4'd0);
        step(1'b0, 8'hAA);
        step(1'b0, 8'hAA);
        check_dir("overlap_pre", 1'b0, 4'd0);
        step(1'b0, 8'hAF);
        check_dir("overlap", 1'b0, 4'd1);
        send_payload(10);
        send_hdr(8'h55, 8'hBA);
        check_dir("ov_hdr2", 1'b0, 4'd1);
        send_payload(10);
        send_hdr(8'hAA, 8'hAF);
        check_dir("ov_lock", 1'b1, 4'd1);

        // Reset mid-lock at position 6
        send_payload(5);
        check_dir("pos6", 1'b1, 4'd6);
        step(1'b1, rnd_byte());
        check_dir("midlock_reset", 1'b0, 4'd0);
        for (int i = 0; i < 3; i++) begin
            send_hdr(8'h55, 8'hBA);
            check_dir("relock_seq", (i == 2), 4'd1);
            send_payload(10);
        end
        check("sb_empty", 5'(sb.size()), 5'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
